divisor_restas: RTL and testbench

DIVISOR_RESTAS -- requirements
Module: divisor_restas

---
 rtl/div_pkg.sv | 5 +
 rtl/restador_nb.sv | 11 +
 rtl/divisor_restas.sv | 87 ++++++++
 tb/tb_divisor_restas.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the restoring divider
package div_pkg;
  localparam int ANCHO_DEF = 5;
  typedef enum logic [1:0] {IDLE, CALC, FIN} estado_t;
endpackage

// File: rtl/restador_nb.sv
// restador_nb: N-bit unsigned subtractor returning difference and borrow
module restador_nb #(
  parameter int N = 6
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] dif,
  output logic         borrow
);
  assign {borrow, dif} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/divisor_restas.sv
// divisor_restas: restoring shift-subtract unsigned divider, one quotient bit per cycle
module divisor_restas
  import div_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [ANCHO-1:0] dividendo,
  input  logic [ANCHO-1:0] divisor,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] residuo,
  output logic             div_cero
);
  localparam int CW = ANCHO > 1 ? $clog2(ANCHO) : 1;
  estado_t          estado;
  logic [CW-1:0]    cnt;
  logic [ANCHO-1:0] p, dvd, dsr, p_nx, q_nx;
  logic [ANCHO:0]   sh, dif, qsh;
  logic             borrow, unused;
  // dvd shifts out dividend bits at the top while quotient bits enter at the bottom
  assign sh   = {p, dvd[ANCHO-1]};
  assign qsh  = {dvd, ~borrow};
  assign q_nx = qsh[ANCHO-1:0];
  assign p_nx = borrow ? sh[ANCHO-1:0] : dif[ANCHO-1:0];
  assign unused = dif[ANCHO];
  restador_nb #(.N(ANCHO + 1)) u_res (
    .a      (sh),
    .b      ({1'b0, dsr}),
    .dif    (dif),
    .borrow (borrow)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= IDLE;
      cnt      <= '0;
      p        <= '0;
      dvd      <= '0;
      dsr      <= '0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
      cociente <= '0;
      residuo  <= '0;
      div_cero <= 1'b0;
    end else begin
      case (estado)
        IDLE: if (inicio) begin
          dvd     <= dividendo;
          dsr     <= divisor;
          p       <= '0;
          cnt     <= CW'(ANCHO - 1);
          ocupado <= 1'b1;
          if (divisor == '0) begin
            estado   <= FIN;
            listo    <= 1'b1;
            cociente <= '1;
            residuo  <= dividendo;
            div_cero <= 1'b1;
          end else begin
            estado   <= CALC;
            div_cero <= 1'b0;
          end
        end
        CALC: begin
          p   <= p_nx;
          dvd <= q_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            estado   <= FIN;
            listo    <= 1'b1;
            cociente <= q_nx;
            residuo  <= p_nx;
          end
        end
        FIN: begin
          estado  <= IDLE;
          listo   <= 1'b0;
          ocupado <= 1'b0;
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divisor_restas.sv
// tb_divisor_restas: directed vector table plus corner sequences for divisor_restas
module tb_divisor_restas;
  localparam int W = 5;
  logic         clk = 1'b0, rst_n = 1'b0, inicio = 1'b0;
  logic [W-1:0] dividendo = '0, divisor = '0;
  logic         ocupado, listo, div_cero;
  logic [W-1:0] cociente, residuo;
  int tests = 0, fails = 0;

  divisor_restas #(.ANCHO(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inicio    (inicio),
    .dividendo (dividendo),
    .divisor   (divisor),
    .ocupado   (ocupado),
    .listo     (listo),
    .cociente  (cociente),
    .residuo   (residuo),
    .div_cero  (div_cero)
  );

  always #5 clk = ~clk;

  typedef struct {int dd; int ds; int q; int r; int z; int lat;} vec_t;
  vec_t v [9];

  task automatic check(input string n, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic go(input int dd, input int ds);
    dividendo = W'(dd);
    divisor   = W'(ds);
    inicio    = 1'b1;
  endtask

  task automatic wait_listo(input int k0, output int k);
    k = k0;
    while (!listo && k < 3 * W) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // accepts at the next edge, scrambles operands, waits for listo and checks results
  task automatic chk(input string n, input int q, input int r, input int z, input int lat);
    int k;
    @(posedge clk);
    #1;
    inicio    = 1'b0;
    dividendo = ~dividendo;
    divisor   = ~divisor;
    wait_listo(1, k);
    check({n, " latency"}, k, lat);
    check({n, " listo"}, int'(listo), 1);
    check({n, " cociente"}, int'(cociente), q);
    check({n, " residuo"}, int'(residuo), r);
    check({n, " div_cero"}, int'(div_cero), z);
    @(posedge clk);
    #1;
    check({n, " listo pulse"}, int'(listo), 0);
    check({n, " ocupado idle"}, int'(ocupado), 0);
  endtask

  initial begin
    int k;
    bit seen;
    v = '{'{23, 4, 5, 3, 0, 6}, '{31, 1, 31, 0, 0, 6}, '{7, 9, 0, 7, 0, 6},
          '{13, 0, 31, 13, 1, 1}, '{12, 5, 2, 2, 0, 6}, '{0, 3, 0, 0, 0, 6},
          '{31, 31, 1, 0, 0, 6}, '{0, 0, 31, 0, 1, 1}, '{30, 7, 4, 2, 0, 6}};
    #1;
    check("rst ocupado", int'(ocupado), 0);
    check("rst listo", int'(listo), 0);
    check("rst cociente", int'(cociente), 0);
    check("rst residuo", int'(residuo), 0);
    check("rst div_cero", int'(div_cero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      go(v[i].dd, v[i].ds);
      chk($sformatf("v%0d", i), v[i].q, v[i].r, v[i].z, v[i].lat);
    end
    // inicio during CALC is ignored, inicio during FIN is ignored, then accepted in IDLE
    go(30, 7);
    @(posedge clk);
    #1;
    inicio = 1'b0;
    dividendo = 5'd1;
    divisor = 5'd1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    wait_listo(4, k);
    check("busy latency", k, 6);
    check("busy cociente", int'(cociente), 4);
    check("busy residuo", int'(residuo), 2);
    go(1, 1);
    @(posedge clk);
    #1;
    check("fin ignore ocupado", int'(ocupado), 0);
    chk("after fin", 1, 0, 0, 6);
    // reset mid-CALC aborts without listo
    go(25, 3);
    repeat (3) begin
      @(posedge clk);
      #1;
      inicio = 1'b0;
    end
    check("mid ocupado", int'(ocupado), 1);
    rst_n = 1'b0;
    #1;
    check("abort ocupado", int'(ocupado), 0);
    check("abort cociente", int'(cociente), 0);
    check("abort residuo", int'(residuo), 0);
    check("abort div_cero", int'(div_cero), 0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen |= listo;
    end
    check("abort listo", int'(seen), 0);
    rst_n = 1'b1;
    go(25, 3);
    chk("post rst", 8, 1, 0, 6);
    for (int dd = 0; dd < 32; dd++)
      for (int ds = 1; ds < 32; ds++) begin
        go(dd, ds);
        chk($sformatf("sweep %0d/%0d", dd, ds), dd / ds, dd % ds, 0, 6);
      end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
